dmem_responder: RTL and testbench

- Data-memory slave that terminates the LSU data interface (req/gnt/rvalid protocol) and drives a single-port SRAM macro.
- Handles byte/half/word and capability (tagged 64-bit) accesses, bus errors and the LR/SC reservation.
- Sits between the load/store pipeline's data port and the data-TCM RAM, behind an optional arbiter that supplies ram_gnt_i.

---
 rtl/super_pkg.sv | 27 ++
 rtl/dmem_rsv_tracker.sv | 63 ++++++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/super_pkg.sv
// Shared types and widths for the data-memory slave.
//   MemW             : data bus width, 64 data bits plus one capability tag
//   dmem_resp_pipe_t : per-request bookkeeping carried down the response pipe
//   lane_wmask       : RAM write mask for a 32-bit lane write
package super_pkg;

    localparam int unsigned MemW   = 65;
    localparam int unsigned LaneW  = 32;
    localparam int unsigned WmaskW = 9;
    localparam int unsigned LineW  = 29;

    typedef struct packed {
        logic valid;
        logic err;
        logic is_cap;
        logic lane;
        logic sc;
        logic sc_fail;
    } dmem_resp_pipe_t;

    // Byte mask for a 32-bit lane write; the tag bit is always written so
    // any data write clears the line's capability tag.
    function automatic logic [WmaskW-1:0] lane_wmask(input logic lane, input logic [3:0] be);
        return {1'b1, lane ? {be, 4'b0000} : {4'b0000, be}};
    endfunction

endpackage

// File: rtl/dmem_rsv_tracker.sv
// LR/SC reservation register with set/clear priority and SC check.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   accept        : LSU access accepted this cycle
//   err           : accepted access has a bus error
//   lr, sc        : access is LR / SC (mutually exclusive, SC wins upstream)
//   wr            : access is a non-SC write
//   line          : addr[31:3] of the access
//   ext_wr        : another master writes ext_line
//   ext_line      : ext_wr address[31:3]
//   sc_fail_c     : combinational; an SC with this line would fail
module dmem_rsv_tracker
    import super_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             accept,
    input  logic             err,
    input  logic             lr,
    input  logic             sc,
    input  logic             wr,
    input  logic [LineW-1:0] line,
    input  logic             ext_wr,
    input  logic [LineW-1:0] ext_line,
    output logic             sc_fail_c
);

    logic             rsv_valid_q;
    logic [LineW-1:0] rsv_line_q;
    logic             rsv_valid_d;
    logic [LineW-1:0] rsv_line_d;
    logic             set_rsv;
    logic             clr_rsv;

    // Reservation register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsv_valid_q <= 1'b0;
            rsv_line_q  <= '0;
        end else begin
            rsv_valid_q <= rsv_valid_d;
            rsv_line_q  <= rsv_line_d;
        end
    end

    // Set/clear decision; an LR in the same cycle as any clear wins
    always_comb begin
        sc_fail_c   = ~rsv_valid_q | (rsv_line_q != line) | err;
        set_rsv     = accept & lr & ~err;
        clr_rsv     = (accept & sc)
                    | (accept & wr & rsv_valid_q & (rsv_line_q == line))
                    | (ext_wr & rsv_valid_q & (rsv_line_q == ext_line));
        rsv_valid_d = rsv_valid_q;
        rsv_line_d  = rsv_line_q;
        if (set_rsv) begin
            rsv_valid_d = 1'b1;
            rsv_line_d  = line;
        end else if (clr_rsv) begin
            rsv_valid_d = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: terminates the LSU req/gnt/rvalid interface and drives
// a single-port SRAM holding 64-bit lines plus a capability tag.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   data_req_i .. wdata_i  : LSU request (write, byte enables, cap, LR/SC, addr, data)
//   data_gnt_o             : request accepted (combinational, follows ram_gnt_i)
//   data_rvalid_o/err_o    : response valid / bus error, RamLatency cycles after grant
//   data_sc_resp_o         : SC failed
//   data_rdata_o           : read data, formatted from ram_rdata_i
//   ram_gnt_i              : RAM port available this cycle
//   ram_req_o .. wdata_o   : RAM access, line address, write mask and data
//   ram_rdata_i            : RAM read data, RamLatency cycles after ram_req_o
//   ext_wr_i, ext_wr_addr_i: write by another master, for reservation snooping
module dmem_responder
    import super_pkg::*;
#(
    parameter logic [31:0] MemBase    = 32'h8000_0000,
    parameter logic [31:0] MemSize    = 32'h0004_0000,
    parameter int unsigned RamLatency = 1,
    parameter int unsigned RamAw      = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic              data_is_cap_i,
    input  logic [3:0]        data_amo_flag_i,
    input  logic [31:0]       data_addr_i,
    input  logic [MemW-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic              data_err_o,
    output logic              data_sc_resp_o,
    output logic [MemW-1:0]   data_rdata_o,
    input  logic              ram_gnt_i,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [RamAw-1:0]  ram_addr_o,
    output logic [WmaskW-1:0] ram_wmask_o,
    output logic [MemW-1:0]   ram_wdata_o,
    input  logic [MemW-1:0]   ram_rdata_i,
    input  logic              ext_wr_i,
    input  logic [31:0]       ext_wr_addr_i
);

    logic [31:0]     offset;
    logic            in_range;
    logic            is_word;
    logic            acc_err;
    logic            accept;
    logic            is_sc;
    logic            is_lr;
    logic            is_write;
    logic            sc_fail_raw;
    logic            sc_fail;
    dmem_resp_pipe_t entry;
    dmem_resp_pipe_t pipe_q [RamLatency];
    dmem_resp_pipe_t head;
    logic [LaneW-1:0] lane_data;

    // Request decode and error check
    always_comb begin
        offset   = data_addr_i - MemBase;
        in_range = (data_addr_i >= MemBase) && (offset < MemSize);
        is_word  = (data_be_i == 4'hF);
        acc_err  = ~in_range
                 | (data_is_cap_i & (data_addr_i[2:0] != 3'b000))
                 | (~data_is_cap_i & is_word & (data_addr_i[1:0] != 2'b00));
        data_gnt_o = data_req_i & ram_gnt_i;
        accept     = data_req_i & data_gnt_o;
        // LR and SC together is treated as SC; bits 3:2 are reserved
        is_sc      = data_amo_flag_i[1];
        is_lr      = data_amo_flag_i[0] & ~data_amo_flag_i[1];
        is_write   = data_we_i | is_sc;
        sc_fail    = is_sc & sc_fail_raw;
    end

    dmem_rsv_tracker u_rsv (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .accept   (accept),
        .err      (acc_err),
        .lr       (is_lr),
        .sc       (is_sc),
        .wr       (data_we_i & ~is_sc),
        .line     (data_addr_i[31:3]),
        .ext_wr   (ext_wr_i),
        .ext_line (ext_wr_addr_i[31:3]),
        .sc_fail_c(sc_fail_raw)
    );

    // RAM drive; address, mask and data are held at zero when idle
    always_comb begin
        ram_req_o   = accept & ~acc_err & ~sc_fail;
        ram_we_o    = ram_req_o & is_write;
        ram_addr_o  = '0;
        ram_wmask_o = '0;
        ram_wdata_o = '0;
        if (ram_req_o) begin
            ram_addr_o = offset[RamAw+2:3];
        end
        if (ram_we_o) begin
            if (data_is_cap_i) begin
                ram_wmask_o = 9'h1FF;
                ram_wdata_o = data_wdata_i;
            end else begin
                ram_wmask_o = lane_wmask(data_addr_i[2], data_be_i);
                ram_wdata_o = {1'b0, data_wdata_i[LaneW-1:0], data_wdata_i[LaneW-1:0]};
            end
        end
    end

    // Response shift register entry captured at accept
    always_comb begin
        entry         = '0;
        entry.valid   = accept;
        entry.err     = acc_err;
        entry.is_cap  = data_is_cap_i;
        entry.lane    = data_addr_i[2];
        entry.sc      = is_sc;
        entry.sc_fail = sc_fail;
    end

    // Fixed-latency response pipe, advanced every cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RamLatency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= entry;
            for (int unsigned i = 1; i < RamLatency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Response formatting; lane selection only, the LSU aligns and extends
    always_comb begin
        head           = pipe_q[RamLatency-1];
        lane_data      = head.lane ? ram_rdata_i[2*LaneW-1:LaneW] : ram_rdata_i[LaneW-1:0];
        data_rvalid_o  = head.valid;
        data_err_o     = head.valid & head.err;
        data_sc_resp_o = head.valid & head.sc & head.sc_fail & ~head.err;
        data_rdata_o   = '0;
        if (head.valid & ~head.err & ~head.sc_fail) begin
            if (head.is_cap) begin
                data_rdata_o = ram_rdata_i;
            end else begin
                data_rdata_o = {{(MemW-LaneW){1'b0}}, lane_data};
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_amo_flag_i[3:2], ext_wr_addr_i[2:0], offset};

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import super_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // DUT 1: RamLatency = 1
    logic        req1 = 0, we1 = 0, cap1 = 0, rgnt1 = 0, ext1 = 0;
    logic [3:0]  be1 = 0, amo1 = 0;
    logic [31:0] addr1 = 0, extaddr1 = 0;
    logic [64:0] wd1 = 0;
    logic        gnt1, rv1, err1, sc1, rreq1, rwe1;
    logic [64:0] rd1o, rwd1, rrd1;
    logic [14:0] raddr1;
    logic [8:0]  rmask1;

    // DUT 2: RamLatency = 2
    logic        req2 = 0, we2 = 0, rgnt2 = 0;
    logic [3:0]  be2 = 0;
    logic [31:0] addr2 = 0;
    logic [64:0] wd2 = 0;
    logic        gnt2, rv2, err2, sc2, rreq2, rwe2;
    logic [64:0] rd2o, rwd2, rrd2;
    logic [14:0] raddr2;
    logic [8:0]  rmask2;

    dmem_responder u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_we_i(we1), .data_be_i(be1),
        .data_is_cap_i(cap1), .data_amo_flag_i(amo1), .data_addr_i(addr1), .data_wdata_i(wd1),
        .data_gnt_o(gnt1), .data_rvalid_o(rv1), .data_err_o(err1), .data_sc_resp_o(sc1),
        .data_rdata_o(rd1o), .ram_gnt_i(rgnt1), .ram_req_o(rreq1), .ram_we_o(rwe1),
        .ram_addr_o(raddr1), .ram_wmask_o(rmask1), .ram_wdata_o(rwd1), .ram_rdata_i(rrd1),
        .ext_wr_i(ext1), .ext_wr_addr_i(extaddr1)
    );

    dmem_responder #(.RamLatency(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req2), .data_we_i(we2), .data_be_i(be2),
        .data_is_cap_i(1'b0), .data_amo_flag_i(4'h0), .data_addr_i(addr2), .data_wdata_i(wd2),
        .data_gnt_o(gnt2), .data_rvalid_o(rv2), .data_err_o(err2), .data_sc_resp_o(sc2),
        .data_rdata_o(rd2o), .ram_gnt_i(rgnt2), .ram_req_o(rreq2), .ram_we_o(rwe2),
        .ram_addr_o(raddr2), .ram_wmask_o(rmask2), .ram_wdata_o(rwd2), .ram_rdata_i(rrd2),
        .ext_wr_i(1'b0), .ext_wr_addr_i(32'h0)
    );

    // Behavioural SRAM models
    logic [64:0] mem1 [32768];
    logic [64:0] mem2 [32768];
    logic [64:0] rq1, rq2a, rq2b;
    assign rrd1 = rq1;
    assign rrd2 = rq2b;

    function automatic logic [64:0] apply_mask(input logic [64:0] old, input logic [8:0] m,
                                               input logic [64:0] w);
        logic [64:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
        if (m[8]) r[64] = w[64];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rreq1) begin
            if (rwe1) mem1[raddr1] <= apply_mask(mem1[raddr1], rmask1, rwd1);
            else      rq1 <= mem1[raddr1];
        end
        if (rreq2) begin
            if (rwe2) mem2[raddr2] <= apply_mask(mem2[raddr2], rmask2, rwd2);
            else      rq2a <= mem2[raddr2];
        end
        rq2b <= rq2a;
    end

    // Samples of the last access on DUT 1
    logic        s_gnt, s_req, s_we, s_rv, s_err, s_sc;
    logic [14:0] s_addr;
    logic [8:0]  s_mask;
    logic [64:0] s_wd, s_rd;

    // One access on DUT 1: request cycle, then response cycle
    task automatic issue(input logic we, input logic [3:0] be, input logic cap,
                         input logic [3:0] amo, input logic [31:0] addr, input logic [64:0] wd);
        @(negedge clk);
        req1 = 1; we1 = we; be1 = be; cap1 = cap; amo1 = amo; addr1 = addr; wd1 = wd; rgnt1 = 1;
        #1;
        s_gnt = gnt1; s_req = rreq1; s_we = rwe1; s_addr = raddr1; s_mask = rmask1; s_wd = rwd1;
        @(negedge clk);
        req1 = 0; we1 = 0; amo1 = 0; cap1 = 0;
        #1;
        s_rv = rv1; s_err = err1; s_rd = rd1o; s_sc = sc1;
    endtask

    task automatic test_reset();
        #1;
        ncmp++; if (rv1 !== 1'b0) begin nfail++; $display("FAIL reset_rvalid: got %b expected 0", rv1); end
        ncmp++; if (rreq1 !== 1'b0) begin nfail++; $display("FAIL reset_ram_req: got %b expected 0", rreq1); end
        ncmp++; if (rd1o !== 65'h0) begin nfail++; $display("FAIL reset_rdata: got %h expected 0", rd1o); end
        ncmp++; if (rv2 !== 1'b0) begin nfail++; $display("FAIL reset_rvalid2: got %b expected 0", rv2); end
    endtask

    task automatic test_word();
        issue(1, 4'hF, 0, 4'h0, 32'h8000_0104, {33'b0, 32'hDEADBEEF});
        ncmp++; if (s_gnt !== 1'b1) begin nfail++; $display("FAIL word_gnt: got %b expected 1", s_gnt); end
        ncmp++; if (s_req !== 1'b1 || s_we !== 1'b1) begin nfail++; $display("FAIL word_ram_wr: got req %b we %b expected 1 1", s_req, s_we); end
        ncmp++; if (s_mask !== 9'h1F0) begin nfail++; $display("FAIL word_wmask: got %h expected 1f0", s_mask); end
        ncmp++; if (s_addr !== 15'h20) begin nfail++; $display("FAIL word_ram_addr: got %h expected 20", s_addr); end
        ncmp++; if (s_wd !== {1'b0, 32'hDEADBEEF, 32'hDEADBEEF}) begin nfail++; $display("FAIL word_wdata: got %h expected 0deadbeefdeadbeef", s_wd); end
        ncmp++; if (s_rv !== 1'b1 || s_err !== 1'b0) begin nfail++; $display("FAIL word_wr_resp: got rv %b err %b expected 1 0", s_rv, s_err); end
        issue(0, 4'hF, 0, 4'h0, 32'h8000_0104, 65'h0);
        ncmp++; if (s_we !== 1'b0 || s_mask !== 9'h0) begin nfail++; $display("FAIL word_rd_drive: got we %b mask %h expected 0 0", s_we, s_mask); end
        ncmp++; if (s_rv !== 1'b1 || s_err !== 1'b0) begin nfail++; $display("FAIL word_rd_resp: got rv %b err %b expected 1 0", s_rv, s_err); end
        ncmp++; if (s_rd !== {33'b0, 32'hDEADBEEF}) begin nfail++; $display("FAIL word_rdata: got %h expected deadbeef", s_rd); end
    endtask

    task automatic test_cap();
        issue(1, 4'hF, 1, 4'h0, 32'h8000_0200, {1'b1, 64'h1122334455667788});
        ncmp++; if (s_mask !== 9'h1FF) begin nfail++; $display("FAIL cap_wmask: got %h expected 1ff", s_mask); end
        issue(0, 4'hF, 1, 4'h0, 32'h8000_0200, 65'h0);
        ncmp++; if (s_rd !== {1'b1, 64'h1122334455667788}) begin nfail++; $display("FAIL cap_rdata: got %h expected 11122334455667788", s_rd); end
        issue(1, 4'b1000, 0, 4'h0, 32'h8000_0203, {33'b0, 32'hAA00_0000});
        ncmp++; if (s_mask !== 9'h108) begin nfail++; $display("FAIL sb_wmask: got %h expected 108", s_mask); end
        issue(0, 4'hF, 1, 4'h0, 32'h8000_0200, 65'h0);
        ncmp++; if (s_rd !== {1'b0, 64'h11223344AA667788}) begin nfail++; $display("FAIL cap_tag_clear: got %h expected 011223344aa667788", s_rd); end
        issue(0, 4'h1, 0, 4'h0, 32'h8000_0201, 65'h0);
        ncmp++; if (s_err !== 1'b0 || s_rd !== {33'b0, 32'hAA667788}) begin nfail++; $display("FAIL byte_rd: got err %b data %h expected 0 aa667788", s_err, s_rd); end
    endtask

    task automatic test_errors();
        issue(0, 4'hF, 0, 4'h0, 32'h7FFF_FFFC, 65'h0);
        ncmp++; if (s_gnt !== 1'b1 || s_req !== 1'b0) begin nfail++; $display("FAIL err_low_drive: got gnt %b req %b expected 1 0", s_gnt, s_req); end
        ncmp++; if (s_rv !== 1'b1 || s_err !== 1'b1 || s_rd !== 65'h0) begin nfail++; $display("FAIL err_low_resp: got rv %b err %b data %h expected 1 1 0", s_rv, s_err, s_rd); end
        issue(0, 4'hF, 1, 4'h0, 32'h8000_0004, 65'h0);
        ncmp++; if (s_req !== 1'b0 || s_err !== 1'b1) begin nfail++; $display("FAIL err_cap_align: got req %b err %b expected 0 1", s_req, s_err); end
        issue(0, 4'hF, 0, 4'h0, 32'h8003_FFFC, 65'h0);
        ncmp++; if (s_req !== 1'b1 || s_err !== 1'b0 || s_addr !== 15'h7FFF) begin nfail++; $display("FAIL top_word: got req %b err %b addr %h expected 1 0 7fff", s_req, s_err, s_addr); end
        issue(0, 4'hF, 0, 4'h0, 32'h8004_0000, 65'h0);
        ncmp++; if (s_req !== 1'b0 || s_err !== 1'b1) begin nfail++; $display("FAIL err_high: got req %b err %b expected 0 1", s_req, s_err); end
        issue(1, 4'hF, 0, 4'h0, 32'h8000_0102, 65'h1);
        ncmp++; if (s_req !== 1'b0 || s_err !== 1'b1) begin nfail++; $display("FAIL err_word_align: got req %b err %b expected 0 1", s_req, s_err); end
    endtask

    task automatic test_lrsc();
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h9);
        ncmp++; if (s_req !== 1'b0 || s_sc !== 1'b1) begin nfail++; $display("FAIL sc_no_rsv: got req %b sc %b expected 0 1", s_req, s_sc); end
        issue(0, 4'hF, 0, 4'h1, 32'h8000_0300, 65'h0);
        ncmp++; if (s_req !== 1'b1 || s_sc !== 1'b0) begin nfail++; $display("FAIL lr: got req %b sc %b expected 1 0", s_req, s_sc); end
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h5);
        ncmp++; if (s_req !== 1'b1 || s_we !== 1'b1 || s_sc !== 1'b0 || s_rv !== 1'b1) begin nfail++; $display("FAIL sc_ok: got req %b we %b sc %b rv %b expected 1 1 0 1", s_req, s_we, s_sc, s_rv); end
        issue(0, 4'hF, 0, 4'h0, 32'h8000_0300, 65'h0);
        ncmp++; if (s_rd !== 65'h5) begin nfail++; $display("FAIL sc_data: got %h expected 5", s_rd); end
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h6);
        ncmp++; if (s_req !== 1'b0 || s_sc !== 1'b1) begin nfail++; $display("FAIL sc_second: got req %b sc %b expected 0 1", s_req, s_sc); end
    endtask

    task automatic test_rsv_lost();
        issue(0, 4'hF, 0, 4'h1, 32'h8000_0300, 65'h0);
        @(negedge clk); ext1 = 1; extaddr1 = 32'h8000_0304;
        @(negedge clk); ext1 = 0;
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h7);
        ncmp++; if (s_sc !== 1'b1 || s_req !== 1'b0) begin nfail++; $display("FAIL ext_same_line: got sc %b req %b expected 1 0", s_sc, s_req); end
        issue(0, 4'hF, 0, 4'h1, 32'h8000_0300, 65'h0);
        @(negedge clk); ext1 = 1; extaddr1 = 32'h8000_0308;
        @(negedge clk); ext1 = 0;
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h7);
        ncmp++; if (s_sc !== 1'b0 || s_req !== 1'b1) begin nfail++; $display("FAIL ext_other_line: got sc %b req %b expected 0 1", s_sc, s_req); end
        issue(0, 4'hF, 0, 4'h1, 32'h8000_0300, 65'h0);
        issue(1, 4'h1, 0, 4'h0, 32'h8000_0305, 65'h0);
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h7);
        ncmp++; if (s_sc !== 1'b1) begin nfail++; $display("FAIL store_clears: got sc %b expected 1", s_sc); end
        // LR and a matching external write in the same cycle: LR wins
        @(negedge clk);
        req1 = 1; we1 = 0; be1 = 4'hF; cap1 = 0; amo1 = 4'h1; addr1 = 32'h8000_0300; rgnt1 = 1;
        ext1 = 1; extaddr1 = 32'h8000_0300;
        @(negedge clk); req1 = 0; amo1 = 0; ext1 = 0;
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0300, 65'h8);
        ncmp++; if (s_sc !== 1'b0 || s_req !== 1'b1) begin nfail++; $display("FAIL lr_wins: got sc %b req %b expected 0 1", s_sc, s_req); end
        issue(1, 4'hF, 0, 4'h3, 32'h8000_0300, 65'h8);
        ncmp++; if (s_sc !== 1'b1 || s_req !== 1'b0) begin nfail++; $display("FAIL lr_sc_both: got sc %b req %b expected 1 0", s_sc, s_req); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  gpat;
        logic [6:0]  rvexp;
        logic [64:0] dexp;
        logic [31:0] vals [4];
        gpat = 4'b1101;
        rvexp = 7'b0110100;
        vals[0] = 32'hA0A0_0400; vals[1] = 32'hB0B0_0404; vals[2] = 32'hC0C0_0408; vals[3] = 32'hD0D0_040C;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req2 = 1; we2 = 1; be2 = 4'hF; addr2 = 32'h8000_0400 + 32'(4 * k); wd2 = {33'b0, vals[k]}; rgnt2 = 1;
        end
        @(negedge clk); req2 = 0; we2 = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 4) begin
                req2 = 1; addr2 = 32'h8000_0400 + 32'(4 * k); rgnt2 = gpat[k];
            end else begin
                req2 = 0; rgnt2 = 1;
            end
            #1;
            if (k < 4) begin
                ncmp++; if (gnt2 !== gpat[k]) begin nfail++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, gnt2, gpat[k]); end
            end
            ncmp++; if (rv2 !== rvexp[k]) begin nfail++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", k, rv2, rvexp[k]); end
            if (rvexp[k]) begin
                dexp = (k == 2) ? {33'b0, vals[0]} : (k == 4) ? {33'b0, vals[2]} : {33'b0, vals[3]};
                ncmp++; if (rd2o !== dexp) begin nfail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, rd2o, dexp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(0, 4'hF, 0, 4'h1, 32'h8000_0500, 65'h0);
        @(negedge clk);
        req1 = 1; we1 = 0; be1 = 4'hF; addr1 = 32'h8000_0500; rgnt1 = 1;
        @(posedge clk); #1 rst_n = 0;
        #2;
        ncmp++; if (rv1 !== 1'b0) begin nfail++; $display("FAIL mid_reset_rvalid: got %b expected 0", rv1); end
        @(negedge clk); req1 = 0;
        @(negedge clk); rst_n = 1;
        #1;
        ncmp++; if (rv1 !== 1'b0) begin nfail++; $display("FAIL post_reset_rvalid: got %b expected 0", rv1); end
        issue(1, 4'hF, 0, 4'h2, 32'h8000_0500, 65'h1);
        ncmp++; if (s_sc !== 1'b1) begin nfail++; $display("FAIL rsv_reset: got sc %b expected 1", s_sc); end
    endtask

    initial begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1;
        test_word();
        test_cap();
        test_errors();
        test_lrsc();
        test_rsv_lost();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
